// File: rtl/neuron_mac.sv
// Four-tap signed dot product with bias and optional ReLU.
// Weights are fetched one per cycle from an external synchronous-read register file.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; operands latched on the accepting edge
//   S_READ  | issue weight reads 0..3; products accumulate one cycle later
//   S_DRAIN | last product arrives; result and done register on exit
module neuron_mac #(
  parameter int RELU_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_data,
  input  logic [15:0] bias,
  output logic        r_en,
  output logic [1:0]  r_adr,
  input  logic [7:0]  r_data,
  output logic        busy,
  output logic        done,
  output logic [18:0] y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_go;
  logic [1:0]         r_cnt;
  logic               r_valid;
  logic [1:0]         r_adr_d;
  logic [31:0]        r_x;
  logic [15:0]        r_bias;
  logic signed [18:0] r_acc;
  logic [18:0]        r_y;
  logic               r_done;

  logic signed [7:0]  w_xk;
  logic signed [15:0] w_prod;
  logic signed [18:0] w_acc_nxt;
  logic signed [18:0] w_sum;
  logic [18:0]        w_res;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    r_en        = 1'b0;
    r_adr       = 2'd0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_go        = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        r_en  = 1'b1;
        r_adr = r_cnt;
        busy  = 1'b1;
        if (r_cnt == 2'd3) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Activation paired with the weight that is arriving now (address from last cycle).
  always_comb begin
    w_xk = r_x[7:0];
    case (r_adr_d)
      2'd0: w_xk = r_x[7:0];
      2'd1: w_xk = r_x[15:8];
      2'd2: w_xk = r_x[23:16];
      2'd3: w_xk = r_x[31:24];
      default: w_xk = r_x[7:0];
    endcase
  end

  assign w_prod    = $signed(r_data) * w_xk;
  assign w_acc_nxt = r_acc + {{3{w_prod[15]}}, w_prod};
  assign w_sum     = w_acc_nxt + {{3{r_bias[15]}}, r_bias};
  assign w_res     = ((RELU_EN != 0) && w_sum[18]) ? 19'd0 : w_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
      r_adr_d <= 2'd0;
      r_x     <= 32'd0;
      r_bias  <= 16'd0;
      r_acc   <= 19'sd0;
      r_y     <= 19'd0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= r_en;
      r_adr_d <= r_adr;
      r_done  <= (r_state == S_DRAIN);
      if (w_go) begin
        r_x    <= x_data;
        r_bias <= bias;
        r_acc  <= 19'sd0;
        r_cnt  <= 2'd0;
      end else begin
        if (r_state == S_READ) r_cnt <= r_cnt + 2'd1;
        if (r_valid)           r_acc <= w_acc_nxt;
      end
      // The final product is folded in directly so y lands on the DRAIN exit edge.
      if (r_state == S_DRAIN) r_y <= w_res;
    end
  end

  assign done = r_done;
  assign y    = r_y;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: a ReLU and a linear instance share stimulus, each with its own
// synchronous-read weight register file; results are checked against an integer model.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x_data;
  logic [15:0] bias;

  logic        a_r_en, b_r_en;
  logic [1:0]  a_r_adr, b_r_adr;
  logic [7:0]  a_r_data, b_r_data;
  logic        a_busy, b_busy, a_done, b_done;
  logic [18:0] a_y, b_y;

  logic [7:0]  mem [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neuron_mac #(.RELU_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .x_data(x_data), .bias(bias),
    .r_en(a_r_en), .r_adr(a_r_adr), .r_data(a_r_data),
    .busy(a_busy), .done(a_done), .y(a_y)
  );

  neuron_mac #(.RELU_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .x_data(x_data), .bias(bias),
    .r_en(b_r_en), .r_adr(b_r_adr), .r_data(b_r_data),
    .busy(b_busy), .done(b_done), .y(b_y)
  );

  always @(posedge clk) begin
    if (a_r_en) a_r_data <= mem[a_r_adr];
    if (b_r_en) b_r_data <= mem[b_r_adr];
  end

  function automatic logic [18:0] model(input logic [31:0] w, input logic [31:0] x,
                                        input logic [15:0] b, input bit relu);
    int s, wk, xk;
    s = $signed(b);
    for (int k = 0; k < 4; k++) begin
      wk = $signed(w[8*k +: 8]);
      xk = $signed(x[8*k +: 8]);
      s += wk * xk;
    end
    if (relu && s < 0) s = 0;
    return s[18:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[k] = w[8*k +: 8];
  endtask

  // One full transaction with cycle-exact handshake checks.
  task automatic do_op(input logic [31:0] w, input logic [31:0] x, input logic [15:0] b,
                       input bit scramble, input bit poke, input string tag);
    logic [18:0] exp_a, exp_b;
    exp_a = model(w, x, b, 1'b1);
    exp_b = model(w, x, b, 1'b0);
    load_w(w);
    x_data = x;
    bias   = b;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (a_r_en !== 1'b1 || a_r_adr !== c[1:0] || a_busy !== 1'b1 || a_done !== 1'b0) begin
        errors++;
        $display("FAIL %s read c=%0d: r_en=%b r_adr=%0d busy=%b done=%b, want 1 %0d 1 0",
                 tag, c, a_r_en, a_r_adr, a_busy, a_done, c);
      end
      if (scramble && c == 0) begin
        x_data = $urandom;
        bias   = 16'($urandom);
      end
      if (poke) start = (c == 1 || c == 3);
      step();
    end
    start = 1'b0;
    checks++;
    if (a_r_en !== 1'b0 || a_r_adr !== 2'd0 || a_busy !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: r_en=%b r_adr=%0d busy=%b done=%b, want 0 0 1 0",
               tag, a_r_en, a_r_adr, a_busy, a_done);
    end
    step();
    checks++;
    if (a_done !== 1'b1 || b_done !== 1'b1 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b/%b busy=%b/%b, want 1/1 0/0",
               tag, a_done, b_done, a_busy, b_busy);
    end
    checks++;
    if (a_y !== exp_a) begin
      errors++;
      $display("FAIL %s y_relu: got %0d want %0d", tag, $signed(a_y), $signed(exp_a));
    end
    checks++;
    if (b_y !== exp_b) begin
      errors++;
      $display("FAIL %s y_lin: got %0d want %0d", tag, $signed(b_y), $signed(exp_b));
    end
    step();
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_y !== exp_a || b_y !== exp_b) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b y=%0d/%0d, want 0 0 %0d/%0d", tag,
               a_done, a_busy, $signed(a_y), $signed(b_y), $signed(exp_a), $signed(exp_b));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    x_data = 32'h01010101;
    bias = 16'd5;
    load_w(32'h04030201);
    repeat (3) step();
    checks++;
    if (a_r_en !== 1'b0 || a_r_adr !== 2'd0 || a_busy !== 1'b0 || a_done !== 1'b0 ||
        a_y !== 19'd0 || b_busy !== 1'b0 || b_y !== 19'd0) begin
      errors++;
      $display("FAIL reset: r_en=%b r_adr=%0d busy=%b done=%b y=%0d/%0d, want all 0",
               a_r_en, a_r_adr, a_busy, a_done, a_y, b_y);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_r_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_start: busy=%b/%b r_en=%b, want 0/0 0", a_busy, b_busy, a_r_en);
    end
  endtask

  task automatic test_basic();
    do_op(32'h04030201, 32'h01010101, 16'd0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_negative();
    do_op(32'hBE8C868E, 32'h01010101, 16'd0, 1'b0, 1'b0, "negative");
  endtask

  task automatic test_extremes();
    do_op(32'h80808080, 32'h80808080, 16'h7FFF, 1'b0, 1'b0, "ext_max");
    do_op(32'h80808080, 32'h7F7F7F7F, 16'h8000, 1'b0, 1'b0, "ext_min");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_op($urandom, $urandom, 16'($urandom), 1'b0, 1'b0, "random");
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < 3; i++)
      do_op($urandom, $urandom, 16'($urandom), 1'b0, 1'b1, "ignored_start");
  endtask

  task automatic test_input_change();
    for (int i = 0; i < 4; i++)
      do_op($urandom, $urandom, 16'($urandom), 1'b1, 1'b0, "input_change");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, x;
    logic [15:0] b;
    logic [18:0] exp_a, exp_b;
    int ndone;
    bit want;
    w = $urandom;
    x = $urandom;
    b = 16'($urandom);
    exp_a = model(w, x, b, 1'b1);
    exp_b = model(w, x, b, 1'b0);
    load_w(w);
    x_data = x;
    bias = b;
    start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 13) start = 1'b0;
      want = (c == 5 || c == 11 || c == 17);
      if (a_done === 1'b1) ndone++;
      checks++;
      if (a_done !== want || b_done !== want) begin
        errors++;
        $display("FAIL b2b done c=%0d: got %b/%b want %b", c, a_done, b_done, want);
      end
      if (want) begin
        checks++;
        if (a_y !== exp_a || b_y !== exp_b) begin
          errors++;
          $display("FAIL b2b y c=%0d: got %0d/%0d want %0d/%0d", c,
                   $signed(a_y), $signed(b_y), $signed(exp_a), $signed(exp_b));
        end
      end
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b count: got %0d done pulses want 3", ndone);
    end
  endtask

  task automatic test_reset_mid();
    load_w(32'h7F7F7F7F);
    x_data = 32'h11223344;
    bias = 16'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (a_r_en !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_y !== 19'd0 ||
        b_busy !== 1'b0 || b_done !== 1'b0 || b_y !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: r_en=%b busy=%b/%b done=%b/%b y=%0d/%0d, want 0 0/0 0/0 0/0",
               a_r_en, a_busy, b_busy, a_done, b_done, a_y, b_y);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (a_done !== 1'b0 || b_done !== 1'b0 || a_busy !== 1'b0 || a_y !== 19'd0) begin
        errors++;
        $display("FAIL reset_mid_quiet c=%0d: done=%b/%b busy=%b y=%0d, want 0/0 0 0",
                 c, a_done, b_done, a_busy, a_y);
      end
    end
    do_op($urandom, $urandom, 16'($urandom), 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_data = 32'd0;
    bias = 16'd0;
    for (int k = 0; k < 4; k++) mem[k] = 8'd0;
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_basic();
    test_reset_mid();
    test_input_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter RELU_EN, default 1: 1 = clamp negative results to 0; 0 = pass the signed result through.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  input  1  request one dot product; honoured only in IDLE.
REQ-005 x_data  input  32  four signed 8-bit activations; x0=[7:0], x1=[15:8], x2=[23:16], x3=[31:24].
REQ-006 bias  input  16  signed bias added to the final sum.
REQ-007 r_en  output  1  read enable to the upstream 4x8 weight register file.
REQ-008 r_adr  output  2  weight address to the register file.
REQ-009 r_data  input  8  signed weight; valid the cycle after r_en=1 (synchronous read).
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse; y is valid from this cycle onward.
REQ-012 y  output  19  signed result, held until the next done.

Function
REQ-013 FSM states SHALL be IDLE, READ and DRAIN.
REQ-014 IDLE transitions: on start=1 at edge T0 -> latch x_data and bias, clear the accumulator, set read count=0, go to READ; otherwise stay in IDLE.
REQ-015 READ SHALL last exactly 4 cycles (T0-T4):
  - r_en=1 throughout
  - r_adr = count, i.e. 0,1,2,3 in successive cycles
  - count increments each edge; exit to DRAIN after count=3
REQ-016 Outside READ: r_en=0 and r_adr=0.
REQ-017 A valid flag SHALL be a one-cycle delay of r_en; while it is 1, acc <= acc + sext(r_data*x[k]), where k is the address issued one cycle earlier.
REQ-018 Arithmetic widths:
  - products: signed 8x8 -> 16 bits
  - accumulator: 19 bits signed
  - bias: sign-extended to 19 bits
  - no overflow is possible; no saturation logic
REQ-019 DRAIN SHALL last 1 cycle. At edge T5:
  - y <= f(acc + p3 + bias), where f = ReLU if RELU_EN=1, else identity
  - done <= 1
  - state <= IDLE
REQ-020 Accumulate timing: products for addresses 0,1,2 accumulate at T2, T3, T4; address 3 accumulates at T5.
REQ-021 Handshake timing:
  - done high for exactly the cycle after T5
  - busy=1 from after T0 through after T4, i.e. in READ and DRAIN
REQ-022 Latency: start sampled at T0 -> done visible after T5 (5 cycles); maximum throughput is one result per 6 cycles.
REQ-023 start=1 while busy SHALL be ignored: no restart, no queuing.
REQ-024 start held high continuously SHALL begin a new computation at every IDLE edge (T6, T12, ...).
REQ-025 x_data and bias changes after T0 SHALL NOT affect the current result.

Reset
REQ-026 rst_n=0 at an edge SHALL set all of the following, regardless of state (mid-READ or DRAIN included):
  - state=IDLE, count=0, acc=0, valid flag=0
  - y=0, done=0, busy=0, r_en=0, r_adr=0
REQ-027 Reset asserted during a computation SHALL produce no done pulse for it; y SHALL NOT take a partial value.
REQ-028 start sampled in the same edge as rst_n=0 SHALL be ignored.

Verification
REQ-029 Regfile loaded w={1,2,3,4}, x={1,1,1,1}, bias=0, start pulse -> r_adr 0,1,2,3 in 4 consecutive cycles; done 5 cycles after start; y=10; busy low after done.
REQ-030 Regfile w={8'h8E,8'h86,8'h8C,8'hBE} (-114,-122,-116,-66), x={1,1,1,1}, bias=0: RELU_EN=1 -> y=0; RELU_EN=0 -> y=-418.
REQ-031 Extremes with RELU_EN=0:
  - all w=-128, x=-128, bias=32767 -> y=98303
  - all w=-128, x=127, bias=-32768 -> y=-97792
REQ-032 Continuation and ignored starts:
  - start held high for 14 cycles -> done pulses every 6 cycles
  - extra start pulses during busy -> no effect on r_adr sequence or y
REQ-033 rst_n=0 for one cycle during the third READ cycle:
  - next cycle: r_en=0, busy=0, y=0, and no done
  - a fresh start afterwards yields the correct result
REQ-034 x_data and bias changed to random values one cycle after start -> y equals the result computed with the values latched at start.
